// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: source, register-write and
// load-size codes plus the controller state type.
package wb_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RS   = 2'b01;
  localparam logic [1:0] RW_RT   = 2'b10;
  localparam logic [1:0] RW_R31  = 2'b11;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;
  localparam logic [1:0] LD_UBYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_WRITE    = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational lane selection and extension of a little-endian memory word,
// plus the alignment check for the requested access size.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  output logic [31:0] value_o,
  output logic        misaligned_o
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Pick the addressed lanes and extend according to the access size.
  always_comb begin
    half_s       = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
    byte_s       = data_i[8*addr_lo_i +: 8];
    value_o      = data_i;
    misaligned_o = 1'b0;
    case (size_i)
      LD_WORD: begin
        value_o      = data_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      LD_HALF: begin
        value_o      = {{16{half_s[15]}}, half_s};
        misaligned_o = addr_lo_i[0];
      end
      LD_BYTE: begin
        value_o      = {{24{byte_s[7]}}, byte_s};
        misaligned_o = 1'b0;
      end
      LD_UBYTE: begin
        value_o      = {24'h000000, byte_s};
        misaligned_o = 1'b0;
      end
      default: begin
        value_o      = data_i;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: selects ALU, link or load data and drives the register
// file write port; loads run a req/ack handshake with a cycle timeout.
module wb_unit
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_src,
  input  logic [1:0]  wb_dest,
  input  logic [1:0]  ld_size,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  reg_write,
  output logic [31:0] write_data,
  output logic        wb_done,
  output logic        wb_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  dest_q, dest_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  rw_q, rw_d;
  logic [31:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  al_addr_s;
  logic [1:0]  al_size_s;
  logic [31:0] al_value_s;
  logic        al_mis_s;

  // In IDLE the aligner only judges alignment of the incoming load; while
  // waiting it extends the returned word using the latched lane and size.
  assign al_addr_s = (state_q == ST_IDLE) ? alu_result[1:0] : lane_q;
  assign al_size_s = (state_q == ST_IDLE) ? ld_size : size_q;

  load_align u_align (
    .data_i       (mem_rd_data),
    .addr_lo_i    (al_addr_s),
    .size_i       (al_size_s),
    .value_o      (al_value_s),
    .misaligned_o (al_mis_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    size_d  = size_q;
    lane_d  = lane_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rw_d    = RW_NONE;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_valid) begin
          case (wb_src)
            WB_ALU: begin
              wd_d    = alu_result;
              rw_d    = wb_dest;
              done_d  = 1'b1;
              state_d = ST_WRITE;
            end
            WB_LINK: begin
              wd_d    = pc + 32'd4;
              rw_d    = wb_dest;
              done_d  = 1'b1;
              state_d = ST_WRITE;
            end
            WB_NONE: begin
              rw_d    = RW_NONE;
              done_d  = 1'b1;
              state_d = ST_WRITE;
            end
            WB_MEM: begin
              if (al_mis_s) begin
                err_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                dest_d  = wb_dest;
                size_d  = ld_size;
                lane_d  = alu_result[1:0];
                addr_d  = {alu_result[31:2], 2'b00};
                req_d   = 1'b1;
                cnt_d   = 8'd0;
                state_d = ST_MEM_WAIT;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rd_ack) begin
          wd_d    = al_value_s;
          rw_d    = dest_q;
          done_d  = 1'b1;
          req_d   = 1'b0;
          state_d = ST_WRITE;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      dest_q  <= RW_NONE;
      size_q  <= LD_WORD;
      lane_q  <= 2'b00;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      rw_q    <= RW_NONE;
      wd_q    <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wb_ready   = (state_q == ST_IDLE);
  assign mem_rd_req = req_q;
  assign mem_addr   = addr_q;
  assign reg_write  = rw_q;
  assign write_data = wd_q;
  assign wb_done    = done_q;
  assign wb_err     = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Randomized self-checking bench for wb_unit against a transaction-level model.
module tb_wb_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [1:0]  wb_src = 2'b00;
  logic [1:0]  wb_dest = 2'b00;
  logic [1:0]  ld_size = 2'b00;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = 32'd0;
  logic [1:0]  reg_write;
  logic [31:0] write_data;
  logic        wb_done;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  wb_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_src      (wb_src),
    .wb_dest     (wb_dest),
    .ld_size     (ld_size),
    .alu_result  (alu_result),
    .pc          (pc),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .reg_write   (reg_write),
    .write_data  (write_data),
    .wb_done     (wb_done),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: value a load of size sz at byte offset a returns from word w.
  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] v;
    case (sz)
      2'b00: v = w;
      2'b01: begin
        v = (w >> (16 * int'(a[1]))) & 32'h0000FFFF;
        if (v >= 32'h00008000) v = v - 32'h00010000;
      end
      2'b10: begin
        v = (w >> (8 * int'(a))) & 32'h000000FF;
        if (v >= 32'h00000080) v = v - 32'h00000100;
      end
      default: v = (w >> (8 * int'(a))) & 32'h000000FF;
    endcase
    return v;
  endfunction

  // One instruction: ack_at = request cycle (1-based) carrying the ack, 0 = never.
  task automatic run_txn(input logic [1:0] src, input logic [1:0] dest, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] pcv,
                         input int ack_at, input logic [31:0] mdata);
    bit mis;
    bit is_load;
    int reqs;
    logic [1:0] exp_rw;
    is_load = (src == 2'b01);
    mis = is_load && ((size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]));
    @(negedge clk);
    check_eq("ready_before", 32'(wb_ready), 32'd1);
    wb_valid = 1'b1; wb_src = src; wb_dest = dest; ld_size = size;
    alu_result = addr; pc = pcv;
    mem_rd_ack = 1'($urandom_range(0, 1));
    mem_rd_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0; wb_src = 2'($urandom); ld_size = 2'($urandom);
    alu_result = $urandom; pc = $urandom; mem_rd_ack = 1'b0;
    if (mis) begin
      check_eq("mis_err", 32'(wb_err), 32'd1);
      check_eq("mis_done", 32'(wb_done), 32'd1);
      check_eq("mis_rw", 32'(reg_write), 32'd0);
      check_eq("mis_req", 32'(mem_rd_req), 32'd0);
      check_eq("mis_ready", 32'(wb_ready), 32'd1);
    end else if (is_load) begin
      check_eq("ld_req_start", 32'(mem_rd_req), 32'd1);
      check_eq("ld_addr", mem_addr, addr & 32'hFFFFFFFC);
      reqs = 0;
      while (mem_rd_req && reqs < 20) begin
        reqs++;
        check_eq("ld_wait_rw", 32'(reg_write), 32'd0);
        check_eq("ld_wait_done", 32'(wb_done), 32'd0);
        mem_rd_ack = (reqs == ack_at);
        mem_rd_data = (reqs == ack_at) ? mdata : $urandom;
        @(posedge clk);
        @(negedge clk);
        mem_rd_ack = 1'b0;
      end
      if (ack_at >= 1 && ack_at <= TO) begin
        check_eq("ld_req_cycles", 32'(reqs), 32'(ack_at));
        check_eq("ld_rw", 32'(reg_write), 32'(dest));
        check_eq("ld_data", write_data, ld_model(mdata, addr[1:0], size));
        check_eq("ld_done", 32'(wb_done), 32'd1);
        check_eq("ld_err", 32'(wb_err), 32'd0);
        check_eq("ld_ready_low", 32'(wb_ready), 32'd0);
      end else begin
        check_eq("to_req_cycles", 32'(reqs), 32'(TO));
        check_eq("to_err", 32'(wb_err), 32'd1);
        check_eq("to_done", 32'(wb_done), 32'd1);
        check_eq("to_rw", 32'(reg_write), 32'd0);
        check_eq("to_ready", 32'(wb_ready), 32'd1);
      end
    end else begin
      exp_rw = (src == 2'b11) ? 2'b00 : dest;
      check_eq("wr_rw", 32'(reg_write), 32'(exp_rw));
      if (exp_rw != 2'b00)
        check_eq("wr_data", write_data, (src == 2'b00) ? pcv - pcv + addr : pcv + 32'd4);
      check_eq("wr_done", 32'(wb_done), 32'd1);
      check_eq("wr_err", 32'(wb_err), 32'd0);
      check_eq("wr_ready_low", 32'(wb_ready), 32'd0);
      check_eq("wr_req", 32'(mem_rd_req), 32'd0);
      mem_rd_ack = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    mem_rd_ack = 1'b0;
    check_eq("post_rw", 32'(reg_write), 32'd0);
    check_eq("post_done", 32'(wb_done), 32'd0);
    check_eq("post_err", 32'(wb_err), 32'd0);
    check_eq("post_ready", 32'(wb_ready), 32'd1);
  endtask

  initial begin
    #1;
    check_eq("rst_rw", 32'(reg_write), 32'd0);
    check_eq("rst_wd", write_data, 32'd0);
    check_eq("rst_req", 32'(mem_rd_req), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_done", 32'(wb_done), 32'd0);
    check_eq("rst_err", 32'(wb_err), 32'd0);
    check_eq("rst_ready", 32'(wb_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(2'b00, 2'b10, 2'b00, 32'hDEADBEEF, 32'h00001000, 0, 32'd0);
    run_txn(2'b10, 2'b11, 2'b00, 32'h12345678, 32'hFFFFFFFC, 0, 32'd0);
    run_txn(2'b01, 2'b01, 2'b10, 32'h00000103, 32'd0, 3, 32'h80FF1234);
    run_txn(2'b01, 2'b01, 2'b11, 32'h00000103, 32'd0, 3, 32'h80FF1234);
    check_eq("ubyte_const", write_data, 32'h00000080);
    run_txn(2'b01, 2'b10, 2'b00, 32'h00000200, 32'd0, 0, 32'h11111111);
    run_txn(2'b01, 2'b10, 2'b00, 32'h00000200, 32'd0, 4, 32'hCAFEF00D);
    run_txn(2'b01, 2'b10, 2'b01, 32'h00000101, 32'd0, 1, 32'h0);
    run_txn(2'b11, 2'b11, 2'b00, 32'h0, 32'h0, 0, 32'd0);

    // Reset in the middle of a load.
    @(negedge clk);
    wb_valid = 1'b1; wb_src = 2'b01; wb_dest = 2'b01; ld_size = 2'b00;
    alu_result = 32'h00000400;
    @(negedge clk);
    wb_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_req", 32'(mem_rd_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(mem_rd_req), 32'd0);
    check_eq("mid_rst_addr", mem_addr, 32'd0);
    check_eq("mid_rst_rw", 32'(reg_write), 32'd0);
    check_eq("mid_rst_wd", write_data, 32'd0);
    check_eq("mid_rst_ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rd_ack = 1'b1; mem_rd_data = 32'h55555555;
    @(negedge clk);
    mem_rd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("post_rst_rw", 32'(reg_write), 32'd0);
      check_eq("post_rst_done", 32'(wb_done), 32'd0);
      @(negedge clk);
    end
    run_txn(2'b00, 2'b01, 2'b00, 32'h0BADF00D, 32'd0, 0, 32'd0);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [31:0] p;
      a = $urandom;
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      run_txn(2'($urandom), 2'($urandom), 2'($urandom), a, p,
              $urandom_range(0, 6), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Write-back stage of the KGP mini-RISC multi-cycle core. It takes one retiring instruction at a time from execute, selects the write-back source (ALU result, link address or data-memory load), and drives `reg_write` / `write_data` into the register file. For loads it runs a request/acknowledge transaction with data memory, including lane selection, sign extension and a timeout.

## Interface
- `TIMEOUT`, default 255: maximum number of `MEM_WAIT` cycles before a load is abandoned (1..255).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: execute offers an instruction; accepted only when `wb_ready`=1.
- `wb_ready` out 1: combinational; 1 iff state is `IDLE`.
- `wb_src` in 2: source select: 00 ALU, 01 load, 10 link, 11 no write.
- `wb_dest` in 2: register-file write code passed through: 01 rs, 10 rt, 11 r31.
- `ld_size` in 2: load size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- `alu_result` in 32: ALU output; also used as the load address.
- `pc` in 32: PC of the retiring instruction.
- `mem_rd_req` out 1: load request, held until acknowledged or timed out.
- `mem_addr` out 32: word-aligned load address (low 2 bits forced to 0).
- `mem_rd_ack` in 1: memory returns `mem_rd_data` this cycle.
- `mem_rd_data` in 32: little-endian memory word.
- `reg_write` out 2: register-file write code; nonzero for exactly one cycle per write.
- `write_data` out 32: value to write.
- `wb_done` out 1: one-cycle pulse when an instruction retires, with or without a write.
- `wb_err` out 1: one-cycle pulse on a misaligned load or timeout; no write occurs.

## Operation
- States: `IDLE`, `MEM_WAIT`, `WRITE`.
- In `IDLE`, `wb_valid`=1 accepts the instruction. The unit latches `wb_dest`, `ld_size`, the low address bits, and the computed data.
  - src 00: data = `alu_result`; go to `WRITE`.
  - src 10: data = `pc`+4, modulo 2^32; go to `WRITE`.
  - src 11: go to `WRITE` with the latched dest forced to 00.
  - src 01, aligned: word needs addr[1:0]=00; half needs addr[0]=0; bytes are always aligned. Register `mem_addr`={addr[31:2],2'b00}, set `mem_rd_req`=1, clear the timeout counter, and go to `MEM_WAIT`.
  - src 01, misaligned: pulse `wb_err` and `wb_done` next cycle. No request and no write; stay in `IDLE`.
- In `MEM_WAIT`, the counter increments each cycle.
  - `mem_rd_ack`=1: data = aligned and extended `mem_rd_data`; drop `mem_rd_req`; go to `WRITE`.
  - Otherwise, when the counter reaches `TIMEOUT`-1: drop `mem_rd_req`; pulse `wb_err` and `wb_done`; go to `IDLE`.
  - Ack in the expiry cycle wins: the load completes normally.
- Lane extraction:
  - Half: lane addr[1], then sign-extended.
  - Byte: lane addr[1:0], then sign- or zero-extended per `ld_size`.
- In `WRITE`, `reg_write`=latched dest, `write_data`=latched data and `wb_done`=1 for that one cycle; then go to `IDLE`.
- `mem_rd_ack` outside `MEM_WAIT` is ignored. `wb_valid` while `wb_ready`=0 is ignored.
- Upstream holds rs/rt stable from acceptance until `wb_done`; the register file decodes the write target from them.

## Timing
- All outputs except `wb_ready` are registered.
- Reset values: state `IDLE`; `reg_write`=00; `write_data`=0; `mem_rd_req`=0; `mem_addr`=0; `wb_done`=0; `wb_err`=0; counter 0.
- `rst_n` low takes effect immediately, including mid-load. An ack arriving after reset is ignored.
- ALU, link and no-write sources: accept in cycle N; `WRITE` outputs in N+1; `wb_ready`=1 again in N+2.
- Load: `mem_rd_req` is high from N+1 through the ack cycle A inclusive; `WRITE` outputs in A+1.
- Timeout: `mem_rd_req` is high for exactly `TIMEOUT` cycles; `wb_err` pulses in the cycle after the last request cycle.
- Misaligned load: `wb_err` and `wb_done` pulse in N+1; `wb_ready` stays 1.

## Structure
- Package `wb_pkg` holds:
  - `wb_src` codes `WB_ALU`, `WB_MEM`, `WB_LINK`, `WB_NONE`;
  - `reg_write` codes `RW_NONE`, `RW_RS`, `RW_RT`, `RW_R31`;
  - `ld_size` codes;
  - the state enum.
- Sub-module `load_align` is purely combinational. It takes the data word, addr[1:0] and `ld_size`, and produces the 32-bit extended value and a misaligned flag.

## Test plan
- ALU: src=00, dest=10, `alu_result`=0xDEADBEEF → next cycle `reg_write`=10, `write_data`=0xDEADBEEF and `wb_done`=1, all for one cycle.
- Link wrap: src=10, dest=11, `pc`=0xFFFFFFFC → `reg_write`=11, `write_data`=0x00000000.
- Signed byte load: src=01, `ld_size`=10, addr 0x00000103, ack after 3 cycles with data 0x80FF1234 → `mem_addr`=0x100, `mem_rd_req` high 3 cycles, then `write_data`=0xFFFFFF80. Repeat with `ld_size`=11 → 0x00000080.
- Timeout: `TIMEOUT`=4, load with no ack → `mem_rd_req` high 4 cycles, then `wb_err`=`wb_done`=1 and `reg_write` stays 00. An ack in the 4th cycle instead completes the load.
- Misaligned: half load at 0x101 → `wb_err` next cycle, no `mem_rd_req`, `reg_write`=00, `wb_ready` stays 1.
- Reset mid-load: drop `rst_n` during `MEM_WAIT` → all outputs 0 immediately. An ack after release causes no write; the next ALU instruction works normally.
